ha_array_accumulator: RTL and testbench
=======================================

HA_ARRAY_ACCUMULATOR -- requirements
Module: ha_array_accumulator

Interface
REQ-001 Parameter ROWS, default 4, number of ha_array row pairs; only 4 is supported.
REQ-002 Parameter B_W, default 7, width of each ha_array_<i>_b bus.
REQ-003 Parameter T_W, default 9, width of each ha_array_<i>_t bus.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  all eight ha_array buses hold a valid row set.
REQ-007 in_ready  output  1  block can capture a row set.
REQ-008 ha_array_0_b .. ha_array_3_b  input  7 each  carry rows, bit k weighted 2^(k+2+2i) for row i.
REQ-009 ha_array_0_t .. ha_array_3_t  input  9 each  sum rows, bit k weighted 2^(k+2i) for row i.
REQ-010 out_valid  output  1  product and ovf are valid.
REQ-011 out_ready  input  1  downstream accepts product.
REQ-012 product  output  16  reduced (approximate) product, saturated.
REQ-013 ovf  output  1  unsaturated sum exceeded 16'hFFFF.

Function
REQ-014 Row value R_i SHALL be (t_i + (b_i << 2)) << (2*i), computed at 17-bit width.
REQ-015 Result SHALL be S = R_0 + R_1 + R_2 + R_3, held in a 17-bit accumulator (max possible 86615, no wrap).
REQ-016 FSM states SHALL be IDLE, ACC, DONE; reset state IDLE.
REQ-017 in_ready SHALL be 1 exactly in IDLE; in_valid is ignored outside IDLE.
REQ-018 IDLE: on in_valid & in_ready at an edge, all 64 input bits SHALL be registered, accumulator cleared, row counter set to 0, state -> ACC.
REQ-019 ACC: each edge SHALL add R_cnt (from registered rows) to the accumulator and increment cnt; the edge with cnt=3 SHALL move to DONE.
REQ-020 Latency: out_valid SHALL rise exactly 5 edges after the accepting edge (1 capture + 4 accumulate); inputs may change after acceptance without effect.
REQ-021 DONE: out_valid=1; product = S[16] ? 16'hFFFF : S[15:0]; ovf = S[16].
REQ-022 product and ovf SHALL stay stable while out_valid=1 and out_ready=0 (indefinite back-pressure).
REQ-023 DONE with out_ready=1 at an edge: state -> IDLE, out_valid deasserts next cycle; no new capture on that same edge.
REQ-024 out_valid SHALL be 0 in IDLE and ACC; product/ovf outside DONE SHALL hold last registered value (0 after reset).
REQ-025 Throughput: one row set per 6 cycles minimum with out_ready tied high.
REQ-026 Row counter SHALL be 2 bits; it never wraps past 3 within one operation.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, in_ready=1 after release, out_valid=0, product=0, ovf=0, counter=0, accumulator=0, registered rows=0.
REQ-028 Reset asserted during ACC or DONE SHALL abandon the operation; no out_valid for it after release.
REQ-029 First capture SHALL be possible on the first rising edge with rst_n high.

Verification
REQ-030 All buses 0, in_valid 1 cycle, out_ready=1 -> out_valid 5 edges later, product=0, ovf=0, in_ready back 1 next cycle.
REQ-031 Only ha_array_0_t=9'h001 -> product=1; only ha_array_3_b[6]=1 -> product=16384; only ha_array_2_t[8]=1 -> product=4096.
REQ-032 All input bits 1 -> S=86615, product=16'hFFFF, ovf=1.
REQ-033 x=y=8'hFF rows per team's ha_array generator -> product equals generator's reference model sum; out_ready low 3 cycles -> product stable, out_valid held, in_ready=0 throughout.
REQ-034 rst_n pulsed low during ACC cnt=2 -> out_valid never asserts for that op, in_ready=1 after release, next op (ha_array_1_t=9'h003 only, product=12) correct.
REQ-035 in_valid held high continuously with out_ready=1 and random rows -> one result every 6 cycles, each matching the model, no dropped or duplicated results.

Source files
------------

// File: rtl/ha_array_accumulator.sv
// Multi-cycle reducer for four half-adder-array row pairs: captures a row set,
// adds one weighted row per cycle into a 17-bit accumulator, presents a saturated 16-bit product.
module ha_array_accumulator #(
  parameter int ROWS = 4,
  parameter int B_W  = 7,
  parameter int T_W  = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B_W-1:0] ha_array_0_b,
  input  logic [B_W-1:0] ha_array_1_b,
  input  logic [B_W-1:0] ha_array_2_b,
  input  logic [B_W-1:0] ha_array_3_b,
  input  logic [T_W-1:0] ha_array_0_t,
  input  logic [T_W-1:0] ha_array_1_t,
  input  logic [T_W-1:0] ha_array_2_t,
  input  logic [T_W-1:0] ha_array_3_t,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [15:0]    product,
  output logic           ovf
);

  localparam int ACC_W = 17;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [B_W-1:0]   r_b [ROWS];
  logic [T_W-1:0]   r_t [ROWS];
  logic [15:0]      r_product;
  logic             r_ovf;

  logic [B_W-1:0]   w_in_b [ROWS];
  logic [T_W-1:0]   w_in_t [ROWS];
  logic [ACC_W-1:0] w_row  [ROWS];
  logic [ACC_W-1:0] w_sum;

  assign w_in_b[0] = ha_array_0_b;
  assign w_in_b[1] = ha_array_1_b;
  assign w_in_b[2] = ha_array_2_b;
  assign w_in_b[3] = ha_array_3_b;
  assign w_in_t[0] = ha_array_0_t;
  assign w_in_t[1] = ha_array_1_t;
  assign w_in_t[2] = ha_array_2_t;
  assign w_in_t[3] = ha_array_3_t;

  // Carry row sits two bit positions above its sum row; row pair i is offset by 2*i.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign w_row[gi] = (ACC_W'(r_t[gi]) + (ACC_W'(r_b[gi]) << 2)) << (2 * gi);
    end
  endgenerate

  assign w_sum = r_acc + w_row[r_cnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_acc     <= '0;
      r_product <= 16'h0000;
      r_ovf     <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        r_b[i] <= '0;
        r_t[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < ROWS; i++) begin
              r_b[i] <= w_in_b[i];
              r_t[i] <= w_in_t[i];
            end
            r_acc   <= '0;
            r_cnt   <= 2'd0;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc <= w_sum;
          if (r_cnt == 2'd3) begin
            // Last row: publish the saturated result on the same edge.
            r_product <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
            r_ovf     <= w_sum[16];
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign product   = r_product;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Directed and streaming checks for ha_array_accumulator against a bit-weight reference sum.
module tb_ha_array_accumulator;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0][6:0] hb;
  logic [3:0][8:0] ht;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     product;
  logic            ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ha_array_accumulator #(.ROWS(4), .B_W(7), .T_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ha_array_0_b(hb[0]), .ha_array_1_b(hb[1]), .ha_array_2_b(hb[2]), .ha_array_3_b(hb[3]),
    .ha_array_0_t(ht[0]), .ha_array_1_t(ht[1]), .ha_array_2_t(ht[2]), .ha_array_3_t(ht[3]),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .ovf(ovf)
  );

  typedef struct {
    string           name;
    logic [3:0][6:0] b;
    logic [3:0][8:0] t;
    logic [15:0]     p;
    logic            o;
    int              stall;
  } vec_t;

  vec_t vecs[10];

  // Reference: sum of every set bit at its documented weight.
  function automatic logic [16:0] model(input logic [3:0][6:0] b, input logic [3:0][8:0] t);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 9; k++) if (t[i][k]) s += 32'd1 << (k + 2 * i);
      for (int k = 0; k < 7; k++) if (b[i][k]) s += 32'd1 << (k + 2 + 2 * i);
    end
    return s[16:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0][6:0] b, input logic [3:0][8:0] t,
                              input logic [15:0] p, input logic o, input int stall);
    vec_t v;
    v.name = nm; v.b = b; v.t = t; v.p = p; v.o = o; v.stall = stall;
    return v;
  endfunction

  // Called at a negedge with DUT idle; returns at a negedge with DUT idle again.
  task automatic do_op(input vec_t v);
    int edges;
    chk({v.name, "/in_ready_pre"}, 32'(in_ready), 32'd1);
    hb = v.b; ht = v.t; in_valid = 1'b1; out_ready = (v.stall == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    hb = {$urandom, $urandom}; ht = {$urandom, $urandom};
    edges = 1;
    while (!out_valid && edges < 20) begin
      chk({v.name, "/in_ready_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk); @(negedge clk);
      edges++;
    end
    chk({v.name, "/latency"}, 32'(edges), 32'd5);
    chk({v.name, "/product"}, 32'(product), 32'(v.p));
    chk({v.name, "/ovf"}, 32'(ovf), 32'(v.o));
    for (int s = 0; s < v.stall; s++) begin
      @(posedge clk); @(negedge clk);
      chk({v.name, "/hold_valid"}, 32'(out_valid), 32'd1);
      chk({v.name, "/hold_product"}, 32'(product), 32'(v.p));
      chk({v.name, "/hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({v.name, "/valid_drop"}, 32'(out_valid), 32'd0);
    chk({v.name, "/in_ready_post"}, 32'(in_ready), 32'd1);
    chk({v.name, "/product_kept"}, 32'(product), 32'(v.p));
    $display("op %-10s product=0x%04h ovf=%0d stall=%0d", v.name, product, ovf, v.stall);
  endtask

  initial begin
    logic [3:0][6:0] b;
    logic [3:0][8:0] t;
    logic [16:0]     s;
    logic [16:0]     expq[$];
    int              results;
    int              last_c;

    vecs[0] = mk("zero",    '0, '0, 16'd0, 1'b0, 0);
    vecs[1] = mk("t0_1",    '0, {9'd0, 9'd0, 9'd0, 9'h001}, 16'd1, 1'b0, 0);
    vecs[2] = mk("b3_6",    {7'h40, 7'd0, 7'd0, 7'd0}, '0, 16'd16384, 1'b0, 0);
    vecs[3] = mk("t2_8",    '0, {9'd0, 9'h100, 9'd0, 9'd0}, 16'd4096, 1'b0, 0);
    vecs[4] = mk("all_one", {4{7'h7F}}, {4{9'h1FF}}, 16'hFFFF, 1'b1, 0);
    vecs[5] = mk("b0_1",    {7'd0, 7'd0, 7'd0, 7'h01}, '0, 16'd4, 1'b0, 1);
    vecs[6] = mk("t1_full", '0, {9'd0, 9'd0, 9'h1FF, 9'd0}, 16'd2044, 1'b0, 0);
    vecs[7] = mk("s_65535", {7'h7F, 7'd0, 7'd0, 7'd0}, {9'h1FF, 9'h013, 9'd0, 9'h00F}, 16'hFFFF, 1'b0, 0);
    vecs[8] = mk("s_65536", {7'h7F, 7'd0, 7'd0, 7'd0}, {9'h1FF, 9'h014, 9'd0, 9'd0}, 16'hFFFF, 1'b1, 0);
    // Row set for x=y=8'hFF: every partial product bit is 1.
    b = {7'h7F, 7'h7F, 7'h7F, 7'h3F};
    t = {9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF};
    s = model(b, t);
    vecs[9] = mk("ff_x_ff", b, t, s[16] ? 16'hFFFF : s[15:0], s[16], 3);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; hb = '0; ht = '0;
    repeat (2) @(negedge clk);
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/product", 32'(product), 32'd0);
    chk("reset/ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i]);

    // Abandon an operation with reset while the counter is at 2.
    hb = '1; ht = '1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid/out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid/product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid/in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); @(negedge clk);
      chk("rst_mid/no_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    do_op(mk("t1_3", '0, {9'd0, 9'd0, 9'h003, 9'd0}, 16'd12, 1'b0, 0));

    // Streaming: in_valid held high, out_ready high, fresh random rows every cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    results   = 0;
    last_c    = -1;
    for (int c = 0; c < 60; c++) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("stream/unexpected_result", 32'd1, 32'd0);
        end else begin
          s = expq.pop_front();
          chk("stream/product", 32'(product), 32'(s[16] ? 16'hFFFF : s[15:0]));
          chk("stream/ovf", 32'(ovf), 32'(s[16]));
          $display("stream cycle=%0d product=0x%04h ovf=%0d", c, product, ovf);
        end
        if (last_c >= 0) chk("stream/interval", 32'(c - last_c), 32'd6);
        last_c = c;
        results++;
      end
      hb = {$urandom, $urandom};
      ht = {$urandom, $urandom};
      if (in_ready) expq.push_back(model(hb, ht));
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stream/result_count", 32'(results), 32'd10);
    chk("stream/pending", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
